// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_rx #(
    parameter logic [12:0] BPS_DIV  = 13'd5207,
    parameter logic [12:0] BPS_DIV2 = 13'd2603
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic        sample;
    logic        parity_ok;

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign parity_ok = !par_err_q;
`else
    assign parity_ok = 1'b1;
`endif

    assign sample = (cnt_q == BPS_DIV2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif

        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == BPS_DIV) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 13'd1;
        end

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    par_err_d = ^{shift_q, rx_s_q};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave mid-stop so a start edge half a bit later is caught.
                if (sample) begin
                    state_d = IDLE;
                    if (rx_s_q && parity_ok) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx using a shortened bit period (16 clocks, mid-bit at 7).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam logic [12:0] DIV      = 13'd15;
    localparam logic [12:0] DIV2     = 13'd7;
    localparam int          BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int NUM_VEC    = 7;
`else
    localparam int FRAME_BITS = 10;
    localparam int NUM_VEC    = 5;
`endif
    // Nominal pulse time is the middle of the stop bit, measured from the start edge.
    localparam int LAT_NOM = (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS / 2;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       parBit;
        int         expValid;
        int         expErr;
        logic [7:0] expData;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checkCount = 0;
    int passCount = 0;
    int cycle = 0;
    int startCycle = 0;
    int validCount = 0;
    int errCount = 0;
    int bothCount = 0;
    int lastPulseCycle = 0;
    logic [7:0] pulseData[$];
    vec_t vectors[NUM_VEC];

    uart_rx #(.BPS_DIV(DIV), .BPS_DIV2(DIV2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            validCount <= validCount + 1;
            lastPulseCycle <= cycle;
            pulseData.push_back(rx_data);
        end
        if (frame_err) begin
            errCount <= errCount + 1;
            lastPulseCycle <= cycle;
        end
        if (rx_valid && frame_err) bothCount <= bothCount + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checkCount++;
        if (actual >= lo && actual <= hi) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit);
        startCycle = cycle;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(parBit);
`else
        if (parBit === 1'bx) $display("[TB] note: unknown parity bit ignored");
`endif
        driveBit(stopBit);
        rx = 1'b1;
    endtask

    initial begin
        int baseValid;
        int baseErr;
        int baseQ;
        logic [7:0] par;

        vectors[0] = '{8'h55, 1'b1, 1'b0, 1, 0, 8'h55};
        vectors[1] = '{8'hA7, 1'b0, 1'b1, 0, 1, 8'h55};
        vectors[2] = '{8'h00, 1'b1, 1'b0, 1, 0, 8'h00};
        vectors[3] = '{8'hFF, 1'b1, 1'b0, 1, 0, 8'hFF};
        vectors[4] = '{8'h01, 1'b1, 1'b1, 1, 0, 8'h01};
`ifdef UART_RX_PARITY_EN
        vectors[5] = '{8'h03, 1'b1, 1'b1, 0, 1, 8'h01};
        vectors[6] = '{8'h03, 1'b1, 1'b0, 1, 0, 8'h03};
`endif

        repeat (4) @(posedge clk);
        #1;
        checkOutput("reset rx_data", int'(rx_data), 0);
        checkOutput("reset rx_valid", int'(rx_valid), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle busy", int'(busy), 0);

        for (int i = 0; i < NUM_VEC; i++) begin
            baseValid = validCount;
            baseErr = errCount;
            applyStimulus(vectors[i].data, vectors[i].stopBit, vectors[i].parBit);
            repeat (2 * BIT_CLKS) @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d valid pulses", i), validCount - baseValid, vectors[i].expValid);
            checkOutput($sformatf("vec%0d err pulses", i), errCount - baseErr, vectors[i].expErr);
            checkOutput($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vectors[i].expData));
            if (vectors[i].expValid + vectors[i].expErr > 0)
                checkRange($sformatf("vec%0d pulse latency", i), lastPulseCycle - startCycle,
                           LAT_NOM - 2, LAT_NOM + 5);
        end

        // Short low glitch: must be rejected at the start-bit sample.
        baseValid = validCount;
        baseErr = errCount;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (int'(DIV2) - 1) @(posedge clk);
        #1;
        checkOutput("glitch busy before sample", int'(busy), 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("glitch busy after sample", int'(busy), 0);
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        checkOutput("glitch no valid", validCount - baseValid, 0);
        checkOutput("glitch no err", errCount - baseErr, 0);

        // Back-to-back frames with no idle gap.
        baseValid = validCount;
        baseQ = pulseData.size();
        par = 8'hA5;
        applyStimulus(8'hA5, 1'b1, ^par);
        par = 8'h3C;
        applyStimulus(8'h3C, 1'b1, ^par);
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        checkOutput("b2b valid pulses", validCount - baseValid, 2);
        checkOutput("b2b queue size", pulseData.size() - baseQ, 2);
        if (pulseData.size() - baseQ == 2) begin
            checkOutput("b2b first byte", int'(pulseData[baseQ]), 'hA5);
            checkOutput("b2b second byte", int'(pulseData[baseQ + 1]), 'h3C);
        end
        checkOutput("b2b rx_data", int'(rx_data), 'h3C);

        // Reset during data bit 4 of 0xF0; the line stays high afterwards.
        baseValid = validCount;
        baseErr = errCount;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b0);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort rx_data cleared", int'(rx_data), 0);
        repeat (BIT_CLKS / 2 + 5 * BIT_CLKS) @(posedge clk);
        #1;
        checkOutput("abort no valid", validCount - baseValid, 0);
        checkOutput("abort no err", errCount - baseErr, 0);
        par = 8'h81;
        applyStimulus(8'h81, 1'b1, ^par);
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        checkOutput("post-abort valid", validCount - baseValid, 1);
        checkOutput("post-abort rx_data", int'(rx_data), 'h81);

        checkOutput("valid and err overlap", bothCount, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
